// File: rtl/apbmst.sv
// APB initiator: turns a valid/ready command stream into single APB transfers and
// returns each completion (read data or error) on a valid/ready response channel.
module apbmst #(
  parameter int P_TIMEOUT   = 16,
  parameter int P_RDATA_LAT = 1
) (
  input  logic        I_APBMST_PCLK,
  input  logic        I_APBMST_PRESET_N,
  input  logic        I_APBMST_CMD_VALID,
  output logic        O_APBMST_CMD_READY,
  input  logic        I_APBMST_CMD_WRITE,
  input  logic [31:0] I_APBMST_CMD_ADDR,
  input  logic [31:0] I_APBMST_CMD_WDATA,
  output logic        O_APBMST_RSP_VALID,
  input  logic        I_APBMST_RSP_READY,
  output logic [31:0] O_APBMST_RSP_RDATA,
  output logic        O_APBMST_RSP_ERR,
  output logic [31:0] O_APBMST_PADDR,
  output logic [31:0] O_APBMST_PWDATA,
  output logic        O_APBMST_PWRITE,
  output logic        O_APBMST_PSEL,
  output logic        O_APBMST_PENABLE,
  input  logic [31:0] I_APBMST_PRDATA,
  input  logic        I_APBMST_PREADY,
  output logic [2:0]  O_APBMST_DBG_STATE
);

  // Handshakes: a beat transfers at a rising edge where VALID && READY. RSP_VALID,
  // RSP_RDATA and RSP_ERR hold until that edge; CMD_READY is high only when idle.

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam int CW = ($clog2(P_TIMEOUT + 1) > 5) ? $clog2(P_TIMEOUT + 1) : 5;
  localparam logic [CW-1:0] TO_LAST = (P_TIMEOUT == 0) ? '0 : CW'(P_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;

  assign O_APBMST_CMD_READY = (state == ST_IDLE);
  assign O_APBMST_DBG_STATE = state;

  always_ff @(posedge I_APBMST_PCLK or negedge I_APBMST_PRESET_N) begin
    if (!I_APBMST_PRESET_N) begin
      state              <= ST_IDLE;
      wait_cnt           <= '0;
      O_APBMST_PADDR     <= '0;
      O_APBMST_PWDATA    <= '0;
      O_APBMST_PWRITE    <= 1'b0;
      O_APBMST_PSEL      <= 1'b0;
      O_APBMST_PENABLE   <= 1'b0;
      O_APBMST_RSP_VALID <= 1'b0;
      O_APBMST_RSP_RDATA <= '0;
      O_APBMST_RSP_ERR   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (I_APBMST_CMD_VALID) begin
            if (I_APBMST_CMD_ADDR[1:0] != 2'b00) begin
              // Misaligned: answer with an error without touching the bus.
              O_APBMST_RSP_VALID <= 1'b1;
              O_APBMST_RSP_ERR   <= 1'b1;
              O_APBMST_RSP_RDATA <= '0;
              state              <= ST_RESP;
            end else begin
              O_APBMST_PADDR  <= I_APBMST_CMD_ADDR;
              O_APBMST_PWDATA <= I_APBMST_CMD_WDATA;
              O_APBMST_PWRITE <= I_APBMST_CMD_WRITE;
              O_APBMST_PSEL   <= 1'b1;
              wait_cnt        <= '0;
              state           <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          O_APBMST_PENABLE <= 1'b1;
          state            <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (I_APBMST_PREADY) begin
            O_APBMST_PSEL    <= 1'b0;
            O_APBMST_PENABLE <= 1'b0;
            if (O_APBMST_PWRITE || P_RDATA_LAT == 0) begin
              O_APBMST_RSP_VALID <= 1'b1;
              O_APBMST_RSP_ERR   <= 1'b0;
              O_APBMST_RSP_RDATA <= O_APBMST_PWRITE ? 32'h0 : I_APBMST_PRDATA;
              state              <= ST_RESP;
            end else begin
              state <= ST_CAPTURE;
            end
          end else if (P_TIMEOUT != 0 && wait_cnt == TO_LAST) begin
            // This was the P_TIMEOUT-th ACCESS cycle without PREADY: abort.
            O_APBMST_PSEL      <= 1'b0;
            O_APBMST_PENABLE   <= 1'b0;
            O_APBMST_RSP_VALID <= 1'b1;
            O_APBMST_RSP_ERR   <= 1'b1;
            O_APBMST_RSP_RDATA <= '0;
            state              <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          // The slave presents PRDATA one cycle after it completes the access.
          O_APBMST_RSP_VALID <= 1'b1;
          O_APBMST_RSP_ERR   <= 1'b0;
          O_APBMST_RSP_RDATA <= I_APBMST_PRDATA;
          state              <= ST_RESP;
        end
        ST_RESP: begin
          if (I_APBMST_RSP_READY) begin
            O_APBMST_RSP_VALID <= 1'b0;
            state              <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apbmst.sv
// Bench for apbmst: instance 0 uses P_RDATA_LAT=0, instance 1 uses P_RDATA_LAT=1,
// each driven against its own APB responder with programmable wait states.
module tb_apbmst;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]       pwrite, psel, penable, pready;
  logic [1:0][31:0] cmd_addr, cmd_wdata, rsp_rdata, paddr, pwdata, prdata;
  logic [1:0][2:0]  dbg_state;

  int         waits [2];
  logic [1:0] stuck;
  logic [31:0] model_mem [2][64];
  logic [32:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  apbmst #(.P_TIMEOUT(TO), .P_RDATA_LAT(0)) u_dut0 (
    .I_APBMST_PCLK(clk), .I_APBMST_PRESET_N(rst_n),
    .I_APBMST_CMD_VALID(cmd_valid[0]), .O_APBMST_CMD_READY(cmd_ready[0]),
    .I_APBMST_CMD_WRITE(cmd_write[0]), .I_APBMST_CMD_ADDR(cmd_addr[0]),
    .I_APBMST_CMD_WDATA(cmd_wdata[0]), .O_APBMST_RSP_VALID(rsp_valid[0]),
    .I_APBMST_RSP_READY(rsp_ready[0]), .O_APBMST_RSP_RDATA(rsp_rdata[0]),
    .O_APBMST_RSP_ERR(rsp_err[0]), .O_APBMST_PADDR(paddr[0]),
    .O_APBMST_PWDATA(pwdata[0]), .O_APBMST_PWRITE(pwrite[0]),
    .O_APBMST_PSEL(psel[0]), .O_APBMST_PENABLE(penable[0]),
    .I_APBMST_PRDATA(prdata[0]), .I_APBMST_PREADY(pready[0]),
    .O_APBMST_DBG_STATE(dbg_state[0])
  );

  apbmst #(.P_TIMEOUT(TO), .P_RDATA_LAT(1)) u_dut1 (
    .I_APBMST_PCLK(clk), .I_APBMST_PRESET_N(rst_n),
    .I_APBMST_CMD_VALID(cmd_valid[1]), .O_APBMST_CMD_READY(cmd_ready[1]),
    .I_APBMST_CMD_WRITE(cmd_write[1]), .I_APBMST_CMD_ADDR(cmd_addr[1]),
    .I_APBMST_CMD_WDATA(cmd_wdata[1]), .O_APBMST_RSP_VALID(rsp_valid[1]),
    .I_APBMST_RSP_READY(rsp_ready[1]), .O_APBMST_RSP_RDATA(rsp_rdata[1]),
    .O_APBMST_RSP_ERR(rsp_err[1]), .O_APBMST_PADDR(paddr[1]),
    .O_APBMST_PWDATA(pwdata[1]), .O_APBMST_PWRITE(pwrite[1]),
    .O_APBMST_PSEL(psel[1]), .O_APBMST_PENABLE(penable[1]),
    .I_APBMST_PRDATA(prdata[1]), .I_APBMST_PREADY(pready[1]),
    .O_APBMST_DBG_STATE(dbg_state[1])
  );

  function automatic logic [31:0] seed_word(int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Responders: slave 0 drives PRDATA combinationally while PREADY is high;
  // slave 1 registers PRDATA on its completion edge, garbage at other times.
  for (genvar g = 0; g < 2; g++) begin : g_slv
    logic [31:0] mem [64];
    logic [31:0] junk, rd_q;
    int wcnt;
    initial for (int i = 0; i < 64; i++) mem[i] = seed_word(i);
    always @(posedge clk) begin
      junk <= $urandom;
      rd_q <= $urandom;
      if (psel[g] && penable[g]) begin
        if (pready[g]) begin
          wcnt <= 0;
          if (pwrite[g]) mem[paddr[g][7:2]] <= pwdata[g];
          else rd_q <= mem[paddr[g][7:2]];
        end else wcnt <= wcnt + 1;
      end else wcnt <= 0;
    end
    assign pready[g] = psel[g] && penable[g] && !stuck[g] && (wcnt >= waits[g]);
    assign prdata[g] = (g == 0) ? (pready[g] ? mem[paddr[g][7:2]] : junk) : rd_q;
  end

  // Reference model: outcome from address alignment, responder behaviour and
  // the latency rules (1 cycle misaligned, 2+TO timeout, 3+waits, +1 delayed read).
  task automatic model_txn(input int d, input bit wr, input logic [31:0] addr, wdata,
                           input int w, input bit s, output int e_lat, e_ps, e_pe);
    if (addr[1:0] != 2'b00) begin
      exp_q.push_back({1'b1, 32'h0}); e_lat = 1; e_ps = 0; e_pe = 0;
    end else if (s) begin
      exp_q.push_back({1'b1, 32'h0}); e_lat = 2 + TO; e_ps = TO + 1; e_pe = TO;
    end else begin
      e_lat = 3 + w + ((d == 1 && !wr) ? 1 : 0);
      e_ps  = 2 + w;
      e_pe  = 1 + w;
      if (wr) begin
        model_mem[d][addr[7:2]] = wdata;
        exp_q.push_back({1'b0, 32'h0});
      end else exp_q.push_back({1'b0, model_mem[d][addr[7:2]]});
    end
  endtask

  // Issues one command and returns at the first negedge with RSP_VALID high.
  task automatic run_txn(input int d, input bit wr, input logic [31:0] addr, wdata,
                         input int w, input bit s, output int lat, output logic [31:0] rd,
                         output logic er, output int ps_n, pe_n, addr_bad);
    int t;
    waits[d] = w; stuck[d] = s;
    @(posedge clk); #1;
    cmd_valid[d] = 1'b1; cmd_write[d] = wr; cmd_addr[d] = addr; cmd_wdata[d] = wdata;
    lat = -1; ps_n = 0; pe_n = 0; addr_bad = 0; rd = 'x; er = 1'bx;
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_ready[d] && t < 50);
    @(posedge clk); #1;
    cmd_valid[d] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (psel[d]) begin
        ps_n++;
        if (paddr[d] !== addr || pwrite[d] !== wr || (wr && pwdata[d] !== wdata)) addr_bad++;
      end
      if (penable[d]) pe_n++;
      if (rsp_valid[d]) begin lat = k; rd = rsp_rdata[d]; er = rsp_err[d]; break; end
    end
  endtask

  task automatic release_rsp(input int d);
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({cmd_ready[d], psel[d], penable[d], pwrite[d], rsp_valid[d], rsp_err[d]} !== 6'b100000
          || paddr[d] !== 0 || pwdata[d] !== 0 || rsp_rdata[d] !== 0 || dbg_state[d] !== 3'd0) begin
        n_bad++;
        $display("FAIL reset_state d%0d: rdy/psel/pen/pwr/val/err=%b%b%b%b%b%b paddr=%h pwdata=%h rdata=%h st=%0d, want 100000 0 0 0 0",
                 d, cmd_ready[d], psel[d], penable[d], pwrite[d], rsp_valid[d], rsp_err[d],
                 paddr[d], pwdata[d], rsp_rdata[d], dbg_state[d]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wr_rd_slave();
    int lat, ps, pe, ab, el, eps, epe; logic [31:0] rd; logic er; logic [32:0] ex;
    model_txn(1, 1'b1, 32'h8, 32'h123, 0, 1'b0, el, eps, epe);
    run_txn(1, 1'b1, 32'h8, 32'h123, 0, 1'b0, lat, rd, er, ps, pe, ab);
    ex = exp_q.pop_front();
    n_cmp++; if ({er, rd} !== ex || lat !== el) begin n_bad++; $display("FAIL wr08_rsp: err/rdata=%b/%h lat=%0d, want %b/%h lat=%0d", er, rd, lat, ex[32], ex[31:0], el); end
    n_cmp++; if (ps !== 2 || pe !== 1 || ab !== 0) begin n_bad++; $display("FAIL wr08_bus: psel=%0d pen=%0d addr_bad=%0d, want 2 1 0", ps, pe, ab); end
    release_rsp(1);
    model_txn(1, 1'b0, 32'h8, 32'h0, 0, 1'b0, el, eps, epe);
    run_txn(1, 1'b0, 32'h8, 32'h0, 0, 1'b0, lat, rd, er, ps, pe, ab);
    ex = exp_q.pop_front();
    n_cmp++; if (rd !== 32'h0000_0123 || er !== 1'b0) begin n_bad++; $display("FAIL rd08_data: rdata=%h err=%b, want 00000123 0", rd, er); end
    n_cmp++; if ({er, rd} !== ex || lat !== el) begin n_bad++; $display("FAIL rd08_lat: err/rdata=%b/%h lat=%0d, want %b/%h lat=%0d", er, rd, lat, ex[32], ex[31:0], el); end
    n_cmp++; if (ps !== 2 || pe !== 1) begin n_bad++; $display("FAIL rd08_bus: psel=%0d pen=%0d, want 2 1", ps, pe); end
    release_rsp(1);
  endtask

  task automatic test_wait_states();
    int lat, ps, pe, ab, el, eps, epe; logic [31:0] rd; logic er; logic [32:0] ex;
    model_txn(0, 1'b1, 32'h14, 32'hDEAD_BEEF, 0, 1'b0, el, eps, epe);
    run_txn(0, 1'b1, 32'h14, 32'hDEAD_BEEF, 0, 1'b0, lat, rd, er, ps, pe, ab);
    ex = exp_q.pop_front();
    n_cmp++; if ({er, rd} !== ex || lat !== el) begin n_bad++; $display("FAIL wr14_rsp: err/rdata=%b/%h lat=%0d, want %b/%h lat=%0d", er, rd, lat, ex[32], ex[31:0], el); end
    release_rsp(0);
    model_txn(0, 1'b0, 32'h14, 32'h0, 3, 1'b0, el, eps, epe);
    run_txn(0, 1'b0, 32'h14, 32'h0, 3, 1'b0, lat, rd, er, ps, pe, ab);
    ex = exp_q.pop_front();
    n_cmp++; if (pe !== 4 || ps !== 5) begin n_bad++; $display("FAIL ws3_access: pen=%0d psel=%0d, want 4 5", pe, ps); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || {er, rd} !== ex) begin n_bad++; $display("FAIL ws3_data: rdata=%h err=%b, want deadbeef 0", rd, er); end
    n_cmp++; if (lat !== 6 || lat !== el) begin n_bad++; $display("FAIL ws3_lat: lat=%0d, want 6", lat); end
    release_rsp(0);
  endtask

  task automatic test_timeout();
    int lat, ps, pe, ab, el, eps, epe; logic [31:0] rd; logic er; logic [32:0] ex;
    model_txn(1, 1'b0, 32'h20, 32'h0, 0, 1'b1, el, eps, epe);
    run_txn(1, 1'b0, 32'h20, 32'h0, 0, 1'b1, lat, rd, er, ps, pe, ab);
    ex = exp_q.pop_front();
    n_cmp++; if (pe !== TO || pe !== epe) begin n_bad++; $display("FAIL to_penable: pen=%0d, want %0d", pe, TO); end
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || {er, rd} !== ex) begin n_bad++; $display("FAIL to_rsp: err=%b rdata=%h, want 1 0", er, rd); end
    n_cmp++; if (lat !== el) begin n_bad++; $display("FAIL to_lat: lat=%0d, want %0d", lat, el); end
    release_rsp(1);
    model_txn(1, 1'b0, 32'h8, 32'h0, 1, 1'b0, el, eps, epe);
    run_txn(1, 1'b0, 32'h8, 32'h0, 1, 1'b0, lat, rd, er, ps, pe, ab);
    ex = exp_q.pop_front();
    n_cmp++; if ({er, rd} !== ex || lat !== el) begin n_bad++; $display("FAIL to_next: err/rdata=%b/%h lat=%0d, want %b/%h lat=%0d", er, rd, lat, ex[32], ex[31:0], el); end
    release_rsp(1);
  endtask

  task automatic test_misaligned();
    int lat, ps, pe, ab, el, eps, epe; logic [31:0] rd; logic er; logic [32:0] ex;
    for (int d = 0; d < 2; d++) begin
      model_txn(d, 1'b0, 32'h6, 32'h0, 0, 1'b0, el, eps, epe);
      run_txn(d, 1'b0, 32'h6, 32'h0, 0, 1'b0, lat, rd, er, ps, pe, ab);
      ex = exp_q.pop_front();
      n_cmp++; if (ps !== 0 || pe !== 0) begin n_bad++; $display("FAIL mis_bus d%0d: psel=%0d pen=%0d, want 0 0", d, ps, pe); end
      n_cmp++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || {er, rd} !== ex) begin n_bad++; $display("FAIL mis_rsp d%0d: lat=%0d err=%b rdata=%h, want 1 1 0", d, lat, er, rd); end
      release_rsp(d);
    end
  endtask

  task automatic test_rsp_hold();
    int lat, ps, pe, ab, el, eps, epe; logic [31:0] rd; logic er; logic [32:0] ex;
    model_txn(0, 1'b0, 32'h14, 32'h0, 0, 1'b0, el, eps, epe);
    run_txn(0, 1'b0, 32'h14, 32'h0, 0, 1'b0, lat, rd, er, ps, pe, ab);
    ex = exp_q.pop_front();
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; cmd_addr[0] = 32'h10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid[0] !== 1'b1 || {rsp_err[0], rsp_rdata[0]} !== ex || cmd_ready[0] !== 1'b0 || psel[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable cyc%0d: valid=%b err/rdata=%b/%h cmd_ready=%b psel=%b, want 1 %b/%h 0 0",
                 i, rsp_valid[0], rsp_err[0], rsp_rdata[0], cmd_ready[0], psel[0], ex[32], ex[31:0]);
      end
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0; cmd_valid[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL hold_release: cmd_ready=%b rsp_valid=%b, want 1 0", cmd_ready[0], rsp_valid[0]); end
  endtask

  task automatic test_reset_mid();
    int t; int seen_bad;
    stuck[1] = 1'b1; waits[1] = 0;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b1; cmd_write[1] = 1'b0; cmd_addr[1] = 32'h24;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!penable[1] && t < 10);
    n_cmp++; if (psel[1] !== 1'b1 || penable[1] !== 1'b1) begin n_bad++; $display("FAIL rstmid_access: psel=%b pen=%b, want 1 1", psel[1], penable[1]); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready[1], psel[1], penable[1], pwrite[1], rsp_valid[1], rsp_err[1]} !== 6'b100000
        || paddr[1] !== 0 || pwdata[1] !== 0 || rsp_rdata[1] !== 0 || dbg_state[1] !== 3'd0) begin
      n_bad++;
      $display("FAIL rstmid_async: rdy/psel/pen/pwr/val/err=%b%b%b%b%b%b paddr=%h st=%0d, want 100000 0 0",
               cmd_ready[1], psel[1], penable[1], pwrite[1], rsp_valid[1], rsp_err[1], paddr[1], dbg_state[1]);
    end
    @(negedge clk);
    rst_n = 1'b1; stuck[1] = 1'b0;
    seen_bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0 || psel[1] !== 1'b0) seen_bad++;
    end
    n_cmp++; if (seen_bad !== 0) begin n_bad++; $display("FAIL rstmid_quiet: %0d cycles with rsp_valid/psel high, want 0", seen_bad); end
  endtask

  task automatic test_random();
    int lat, ps, pe, ab, el, eps, epe, d, w; bit wr, s; logic [31:0] rd, addr, wd;
    logic er; logic [32:0] ex;
    for (int n = 0; n < 40; n++) begin
      d    = $urandom_range(0, 1);
      wr   = 1'($urandom_range(0, 1));
      addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wd   = $urandom;
      w    = $urandom_range(0, 4);
      s    = ($urandom_range(0, 15) == 0);
      model_txn(d, wr, addr, wd, w, s, el, eps, epe);
      run_txn(d, wr, addr, wd, w, s, lat, rd, er, ps, pe, ab);
      ex = exp_q.pop_front();
      n_cmp++;
      if ({er, rd} !== ex || lat !== el || ps !== eps || pe !== epe || ab !== 0) begin
        n_bad++;
        $display("FAIL rand%0d d%0d wr%0d a=%h w=%0d s=%0d: err/rdata=%b/%h lat=%0d psel=%0d pen=%0d ab=%0d, want %b/%h lat=%0d psel=%0d pen=%0d ab=0",
                 n, d, wr, addr, w, s, er, rd, lat, ps, pe, ab, ex[32], ex[31:0], el, eps, epe);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_rsp(d);
    end
  endtask

  initial begin
    cmd_valid = '0; cmd_write = '0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = '0;
    stuck = '0; waits[0] = 0; waits[1] = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) model_mem[d][i] = seed_word(i);
    test_reset();
    test_wr_rd_slave();
    test_wait_states();
    test_timeout();
    test_misaligned();
    test_rsp_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
